// File: rtl/echo_indication_arbiter_pkg.sv
// Shared constants and the packed-message layout for the echo indication
// outbound pipe: a 32-bit header (id, length) followed by the method payload.
package echo_indication_arbiter_pkg;
  localparam int PIPE_W = 128;

  localparam logic [15:0] ID_SAY2 = 16'd0;
  localparam logic [15:0] ID_SAY  = 16'd1;
  localparam logic [15:0] ID_LEDS = 16'd2;
  localparam logic [15:0] MSG_LEN = 16'd2;

  localparam int HDR_ID_LSB  = 16;
  localparam int HDR_LEN_LSB = 0;
  localparam int PAY_LSB     = 32;

  localparam int SAY2_W = 16;
  localparam int SAY_W  = 32;
  localparam int LEDS_W = 8;

  typedef logic [PIPE_W-1:0] pipe_msg_t;

  // Every message carries at most 32 payload bits; higher bits stay zero.
  function automatic pipe_msg_t pack_msg(logic [15:0] id, logic [31:0] pay);
    pipe_msg_t m;
    m = '0;
    m[HDR_ID_LSB+:16]  = id;
    m[HDR_LEN_LSB+:16] = MSG_LEN;
    m[PAY_LSB+:32]     = pay;
    return m;
  endfunction
endpackage

// File: rtl/echo_indication_arbiter_rr_arb3.sv
// Three-way combinational arbiter: round-robin after 'last', or fixed
// priority (id 0 highest) when 'fixed' is set.
module rr_arb3 (
  input  logic [2:0] req,
  input  logic [1:0] last,
  input  logic       fixed,
  output logic [2:0] grant,
  output logic [1:0] gnt_id
);
  logic [1:0] w_start;
  int         w_idx;

  always_comb begin
    w_start = fixed ? 2'd0 : ((last == 2'd2) ? 2'd0 : last + 2'd1);
    grant   = '0;
    gnt_id  = '0;
    w_idx   = 0;
    // Walk the search order backwards so the earliest requester overwrites.
    for (int k = 2; k >= 0; k--) begin
      w_idx = int'(w_start) + k;
      if (w_idx >= 3) w_idx = w_idx - 3;
      if (req[w_idx]) begin
        grant  = 3'b001 << w_idx;
        gnt_id = 2'(w_idx);
      end
    end
  end
endmodule

// File: rtl/echo_indication_arbiter.sv
// Funnels say2/say/setLeds indications through one-entry holders and an
// arbiter onto a single registered, flow-controlled outbound pipe word.
module echo_indication_arbiter
  import echo_indication_arbiter_pkg::*;
#(
  parameter int PIPE_WIDTH     = PIPE_W,
  parameter bit FIXED_PRIORITY = 1'b0
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  method_say2__ENA,
  input  logic [SAY2_W-1:0]     method_say2_a,
  input  logic [SAY2_W-1:0]     method_say2_b,
  output logic                  method_say2__RDY,
  input  logic                  method_say__ENA,
  input  logic [SAY_W-1:0]      method_say_v,
  output logic                  method_say__RDY,
  input  logic                  method_setLeds__ENA,
  input  logic [LEDS_W-1:0]     method_setLeds_v,
  output logic                  method_setLeds__RDY,
  output logic                  pipe_enq__ENA,
  output logic [PIPE_WIDTH-1:0] pipe_enq_v,
  input  logic                  pipe_enq__RDY
);
  pipe_msg_t  r_hold [3];
  logic [2:0] r_hvalid;
  logic       r_ovalid;
  pipe_msg_t  r_odata;
  logic [1:0] r_last;

  pipe_msg_t  w_pack [3];
  pipe_msg_t  w_sel;
  logic [2:0] w_ena, w_cap, w_clr, w_grant;
  logic [1:0] w_gid;
  logic       w_load;

  assign w_pack[0] = pack_msg(ID_SAY2, {method_say2_b, method_say2_a});
  assign w_pack[1] = pack_msg(ID_SAY, method_say_v);
  assign w_pack[2] = pack_msg(ID_LEDS, {{(32-LEDS_W){1'b0}}, method_setLeds_v});

  assign w_ena  = {method_setLeds__ENA, method_say__ENA, method_say2__ENA};
  // Strobes into a full holder are dropped; capture and grant are disjoint.
  assign w_cap  = w_ena & ~r_hvalid;
  assign w_load = !r_ovalid || pipe_enq__RDY;
  assign w_clr  = w_load ? w_grant : 3'b000;

  rr_arb3 u_arb (
    .req   (r_hvalid),
    .last  (r_last),
    .fixed (FIXED_PRIORITY),
    .grant (w_grant),
    .gnt_id(w_gid)
  );

  always_comb begin
    w_sel = '0;
    for (int i = 0; i < 3; i++)
      if (w_grant[i]) w_sel = r_hold[i];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_hvalid <= '0;
      r_ovalid <= 1'b0;
      r_odata  <= '0;
      r_last   <= 2'd2;
      for (int i = 0; i < 3; i++) r_hold[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++)
        if (w_cap[i]) r_hold[i] <= w_pack[i];
      r_hvalid <= (r_hvalid | w_cap) & ~w_clr;
      if (w_load) begin
        r_ovalid <= |r_hvalid;
        if (|r_hvalid) begin
          r_odata <= w_sel;
          r_last  <= w_gid;
        end
      end
    end
  end

  assign method_say2__RDY    = !r_hvalid[0];
  assign method_say__RDY     = !r_hvalid[1];
  assign method_setLeds__RDY = !r_hvalid[2];
  assign pipe_enq__ENA       = r_ovalid;
  assign pipe_enq_v          = PIPE_WIDTH'(r_odata);
endmodule

// File: tb/tb_echo_indication_arbiter.sv
// Drives a round-robin and a fixed-priority instance with identical stimulus
// and checks both against a message-level model plus literal expectations.
module tb_echo_indication_arbiter;
  logic        CLK = 1'b0, RST = 1'b1, prdy = 1'b1;
  logic        s2_ena = 0, s_ena = 0, l_ena = 0;
  logic [15:0] s2_a = 0, s2_b = 0;
  logic [31:0] s_v = 0;
  logic [7:0]  l_v = 0;

  wire [2:0]   rdy_r, rdy_f;
  wire         ena_r, ena_f;
  wire [127:0] dat_r, dat_f;

  int nchk = 0, nfail = 0;
  int xlog_r[$], xlog_f[$];

  always #5 CLK = ~CLK;

  echo_indication_arbiter #(.PIPE_WIDTH(128), .FIXED_PRIORITY(1'b0)) u_rr (
    .CLK(CLK), .RST(RST),
    .method_say2__ENA(s2_ena), .method_say2_a(s2_a), .method_say2_b(s2_b),
    .method_say2__RDY(rdy_r[0]),
    .method_say__ENA(s_ena), .method_say_v(s_v), .method_say__RDY(rdy_r[1]),
    .method_setLeds__ENA(l_ena), .method_setLeds_v(l_v), .method_setLeds__RDY(rdy_r[2]),
    .pipe_enq__ENA(ena_r), .pipe_enq_v(dat_r), .pipe_enq__RDY(prdy)
  );

  echo_indication_arbiter #(.PIPE_WIDTH(128), .FIXED_PRIORITY(1'b1)) u_fp (
    .CLK(CLK), .RST(RST),
    .method_say2__ENA(s2_ena), .method_say2_a(s2_a), .method_say2_b(s2_b),
    .method_say2__RDY(rdy_f[0]),
    .method_say__ENA(s_ena), .method_say_v(s_v), .method_say__RDY(rdy_f[1]),
    .method_setLeds__ENA(l_ena), .method_setLeds_v(l_v), .method_setLeds__RDY(rdy_f[2]),
    .pipe_enq__ENA(ena_f), .pipe_enq_v(dat_f), .pipe_enq__RDY(prdy)
  );

  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // sel: 0 = RDY vector, 1 = pipe ENA, 2 = pipe word
  function automatic logic [127:0] dout(int p, int sel);
    if (sel == 0) return {125'd0, (p == 0) ? rdy_r : rdy_f};
    if (sel == 1) return {127'd0, (p == 0) ? ena_r : ena_f};
    return (p == 0) ? dat_r : dat_f;
  endfunction

  // ---------------- message-level model ----------------
  logic        mh_v [2][3];
  logic [63:0] mh_d [2][3];
  logic        mo_v [2];
  logic [63:0] mo_d [2];
  int          mlast [2];
  logic        t_hv [3];
  logic [63:0] t_hd [3];
  int          m_g, m_id;

  function automatic logic [63:0] msg(int id);
    case (id)
      0:       return {s2_b, s2_a, 16'd0, 16'd2};
      1:       return {s_v, 16'd1, 16'd2};
      default: return {24'd0, l_v, 16'd2, 16'd2};
    endcase
  endfunction

  function automatic logic in_ena(int id);
    return (id == 0) ? s2_ena : (id == 1) ? s_ena : l_ena;
  endfunction

  always @(posedge CLK or posedge RST) begin
    for (int p = 0; p < 2; p++) begin
      if (RST) begin
        for (int i = 0; i < 3; i++) begin mh_v[p][i] = 0; mh_d[p][i] = '0; end
        mo_v[p] = 0; mo_d[p] = '0; mlast[p] = 2;
      end else begin
        for (int i = 0; i < 3; i++) begin t_hv[i] = mh_v[p][i]; t_hd[i] = mh_d[p][i]; end
        for (int i = 0; i < 3; i++)
          if (in_ena(i) && !t_hv[i]) begin mh_v[p][i] = 1; mh_d[p][i] = msg(i); end
        if (!mo_v[p] || prdy) begin
          m_g = -1;
          for (int k = 0; k < 3; k++) begin
            m_id = (p == 1) ? k : (mlast[p] + 1 + k) % 3;
            if (m_g < 0 && t_hv[m_id]) m_g = m_id;
          end
          if (m_g >= 0) begin
            mo_v[p] = 1; mo_d[p] = t_hd[m_g]; mh_v[p][m_g] = 0; mlast[p] = m_g;
          end else mo_v[p] = 0;
        end
      end
    end
  end

  // Compare on the falling edge; also log each accepted word's method id.
  always @(negedge CLK) begin
    for (int p = 0; p < 2; p++) begin
      logic [127:0] d;
      chk(p ? "fp.rdy" : "rr.rdy", dout(p, 0), {125'd0, !mh_v[p][2], !mh_v[p][1], !mh_v[p][0]});
      chk(p ? "fp.ena" : "rr.ena", dout(p, 1), {127'd0, mo_v[p]});
      if (mo_v[p]) chk(p ? "fp.data" : "rr.data", dout(p, 2), {64'd0, mo_d[p]});
      d = dout(p, 2);
      if (dout(p, 1) == 128'd1 && prdy && !RST) begin
        if (p == 0) xlog_r.push_back(int'(d[17:16]));
        else        xlog_f.push_back(int'(d[17:16]));
      end
    end
  end

  task automatic tick();
    @(posedge CLK); #2;
  endtask

  task automatic both(string nm, int sel, logic [127:0] exp);
    chk({"rr.", nm}, dout(0, sel), exp);
    chk({"fp.", nm}, dout(1, sel), exp);
  endtask

  int n0_r, n0_f;

  initial begin
    // reset state, before any clock edge
    #3;
    both("rst_rdy", 0, 128'h7);
    both("rst_ena", 1, 128'h0);
    tick(); tick();
    RST = 0;

    // simultaneous: ids 0,1,2 on consecutive cycles
    s2_ena = 1; s2_a = 16'h1111; s2_b = 16'h2222;
    s_ena = 1;  s_v = 32'h3333_3333;
    l_ena = 1;  l_v = 8'h5A;
    tick();
    s2_ena = 0; s_ena = 0; l_ena = 0;
    both("sim_rdy", 0, 128'h0);
    both("sim_ena0", 1, 128'h0);
    tick(); both("sim_w0", 2, 128'h2222_1111_0000_0002);
    tick(); both("sim_w1", 2, 128'h3333_3333_0001_0002);
    tick(); both("sim_w2", 2, 128'h0000_005A_0002_0002);
    tick(); both("sim_done", 1, 128'h0);

    // single say: RDY low one cycle, word two cycles after strobe
    s_ena = 1; s_v = 32'hDEAD_BEEF;
    tick();
    s_ena = 0;
    both("say_rdy_lo", 0, 128'h5);
    both("say_ena_lo", 1, 128'h0);
    tick();
    both("say_ena", 1, 128'h1);
    both("say_word", 2, 128'hDEAD_BEEF_0001_0002);
    both("say_rdy_hi", 0, 128'h7);
    tick(); both("say_done", 1, 128'h0);

    // backpressure: setLeds word held stable while the pipe stalls
    prdy = 0; l_ena = 1; l_v = 8'hA5;
    tick(); l_ena = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      both("bp_ena", 1, 128'h1);
      both("bp_word", 2, 128'h0000_00A5_0002_0002);
    end
    n0_r = xlog_r.size(); n0_f = xlog_f.size();
    prdy = 1;
    tick();
    both("bp_after", 1, 128'h0);
    chk("rr.bp_count", 128'(xlog_r.size() - n0_r), 128'd1);
    chk("fp.bp_count", 128'(xlog_f.size() - n0_f), 128'd1);
    chk("rr.bp_id", 128'(xlog_r[$]), 128'd2);

    // fairness: say2 and say strobing continuously
    xlog_r.delete(); xlog_f.delete();
    s2_ena = 1; s2_a = 16'hA0A0; s2_b = 16'hB0B0; s_ena = 1; s_v = 32'h5A5A_0001;
    repeat (10) tick();
    s2_ena = 0; s_ena = 0;
    repeat (4) tick();
    chk("rr.fair_n", 128'(xlog_r.size() >= 8), 128'd1);
    chk("fp.fair_n", 128'(xlog_f.size() >= 8), 128'd1);
    for (int i = 0; i < 8 && i < xlog_r.size() && i < xlog_f.size(); i++) begin
      chk("rr.fair_id", 128'(xlog_r[i]), 128'(i % 2));
      chk("fp.fair_id", 128'(xlog_f[i]), 128'(i % 2));
    end

    // holder full: extra say strobes ignored, one word per RDY window
    prdy = 0; s_ena = 1; s_v = 32'hA000_0001;
    tick(); s_v = 32'hA000_0002;
    tick(); s_v = 32'hA000_0003;
    tick(); s_v = 32'hA000_0004;
    tick(); s_v = 32'hA000_0005;
    tick();
    both("hf_word1", 2, 128'hA000_0001_0001_0002);
    both("hf_rdy", 0, 128'h5);
    n0_r = xlog_r.size(); n0_f = xlog_f.size();
    prdy = 1; s_v = 32'hA000_0006;
    tick();
    prdy = 0; s_v = 32'hA000_0007;
    both("hf_word3", 2, 128'hA000_0003_0001_0002);
    tick(); s_ena = 0;
    tick();
    chk("rr.hf_count", 128'(xlog_r.size() - n0_r), 128'd1);
    chk("fp.hf_count", 128'(xlog_f.size() - n0_f), 128'd1);
    prdy = 1;
    repeat (4) tick();
    both("hf_drained", 1, 128'h0);

    // round-robin vs fixed priority with say2 and say both pending
    prdy = 0; s2_ena = 1; s2_a = 16'h0C0C; s2_b = 16'h0D0D; s_ena = 1; s_v = 32'h0E0E_0E0E;
    tick(); s2_ena = 0; s_ena = 0;
    tick();
    both("pr_first", 2, 128'h0D0D_0C0C_0000_0002);
    s2_ena = 1;
    tick(); s2_ena = 0;
    prdy = 1;
    tick();
    chk("rr.pr_next", dout(0, 2), 128'h0E0E_0E0E_0001_0002);
    chk("fp.pr_next", dout(1, 2), 128'h0D0D_0C0C_0000_0002);
    repeat (4) tick();

    // async reset mid-stall with every holder full
    prdy = 0; s2_ena = 1; s_ena = 1; l_ena = 1;
    tick(); tick(); tick();
    s2_ena = 0; s_ena = 0; l_ena = 0;
    both("pre_rst_rdy", 0, 128'h0);
    #1 RST = 1;
    #1;
    both("arst_rdy", 0, 128'h7);
    both("arst_ena", 1, 128'h0);
    #10 RST = 0;
    tick(); tick();
    both("no_replay", 1, 128'h0);
    prdy = 1; s2_ena = 1; s2_a = 16'h0101; s2_b = 16'h0202; s_ena = 1; s_v = 32'h0303_0303;
    tick(); s2_ena = 0; s_ena = 0;
    tick();
    both("post_rst_w", 2, 128'h0202_0101_0000_0002);
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
